apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, APB address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles before forced completion; legal range 2..255.
REQ-004 pclk  input  1  clock; all state updates on rising edge.
REQ-005 presetn  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  command request from local side.
REQ-007 cmd_ready  output  1  master can accept a command this cycle.
REQ-008 cmd_write  input  1  1=write, 0=read.
REQ-009 cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data of completed transfer.
REQ-013 rsp_err  output  1  completion had error (pslverr or timeout).
REQ-014 rsp_timeout  output  1  completion was a timeout.
REQ-015 psel, penable, pwrite  output  1 each  APB control.
REQ-016 paddr  output  ADDR_WIDTH; pwdata  output  DATA_WIDTH  APB address/write data.
REQ-017 prdata  input  DATA_WIDTH; pready  input  1; pslverr  input  1  APB responder signals.

Function
REQ-018 SHALL implement FSM IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-019 cmd_ready SHALL be combinational: 1 in IDLE; 1 in ACCESS on the completion cycle (pready=1, or timeout cycle); 0 otherwise.
REQ-020 Command accepted on edge with cmd_valid&&cmd_ready; cmd_write/addr/wdata captured into pwrite/paddr/pwdata; next state SETUP.
REQ-021 SETUP: psel=1, penable=0; always exactly one cycle, then ACCESS.
REQ-022 ACCESS: psel=1, penable=1; paddr, pwrite, pwdata SHALL stay stable throughout SETUP and ACCESS.
REQ-023 ACCESS completes on edge where pready=1; without new command next state IDLE (psel=0, penable=0).
REQ-024 Back-to-back: new command accepted on completion edge -> next state SETUP directly, psel stays 1, penable drops to 0.
REQ-025 Wait counter: cleared on SETUP->ACCESS, +1 per ACCESS cycle with pready=0; if pready=0 in the TIMEOUT-th ACCESS cycle, transfer completes on that edge as timeout.
REQ-026 On completion edge: rsp_valid<=1 next cycle for exactly one cycle; rsp_err<=pslverr (or 1 on timeout); rsp_timeout<=1 only for timeout.
REQ-027 rsp_rdata<=prdata on read completion with pready=1; <=0 on write completion or timeout; holds value while rsp_valid=0.
REQ-028 pslverr and prdata SHALL be sampled only on edge where psel&&penable&&pready.
REQ-029 In IDLE: psel=0, penable=0; paddr, pwdata, pwrite hold last values.
REQ-030 Zero-wait transfer: accept edge T, SETUP cycle T+1, ACCESS T+2, rsp_valid in T+3.
REQ-031 No response backpressure: local side SHALL consume rsp_valid pulse unconditionally.

Reset
REQ-032 presetn=0 SHALL asynchronously force: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter 0.
REQ-033 Reset during SETUP/ACCESS SHALL abort transfer with no rsp_valid for it; first command accepted after presetn rises is treated as new.

Verification
REQ-034 Zero-wait write addr 0x10 data 0xDEADBEEF, pready=1 -> psel 2 cycles, penable 1 cycle, rsp_valid one cycle, rsp_err=0, rsp_rdata=0.
REQ-035 Read addr 0x20, pready low 1 ACCESS cycle then high with prdata 0x12345678 -> ACCESS lasts 2 cycles, rsp_rdata=0x12345678, paddr stable.
REQ-036 Write addr 0xC9 with pslverr=1 at completion -> rsp_err=1, rsp_timeout=0, next command accepted normally.
REQ-037 pready held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, psel drops, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-038 Two commands with cmd_valid continuously high, pready=1 -> psel stays 1 across both, penable pattern 0,1,0,1, two rsp_valid pulses two cycles apart.
REQ-039 presetn asserted mid-ACCESS -> psel/penable low immediately (before next edge), no rsp_valid; post-reset read completes normally.

Source files
------------

// File: rtl/apb_master.sv
// APB master: turns single local commands into APB transfers and returns a
// one-cycle completion pulse with read data and error/timeout status.
//
// Ports:
//   pclk, presetn         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata  command payload, captured on acceptance
//   rsp_valid             one-cycle completion pulse (no backpressure)
//   rsp_rdata/err/timeout completion payload, held between pulses
//   psel/penable/pwrite   registered APB control
//   paddr/pwdata          registered APB address/write data
//   prdata/pready/pslverr APB responder inputs
module apb_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    // Wait count reaching this value with pready low marks the TIMEOUT-th
    // ACCESS cycle.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q;
    logic       timeout_hit;
    logic       complete;
    logic       accept;

    always_comb begin
        timeout_hit = (state_q == StAccess) && !pready && (wait_cnt_q == WaitLast);
        complete    = (state_q == StAccess) && (pready || timeout_hit);
        cmd_ready   = (state_q == StIdle) || complete;
        accept      = cmd_valid && cmd_ready;

        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (complete) state_d = accept ? StSetup : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            // APB control follows the next state so it is registered yet
            // aligned with the phase it describes.
            psel    <= (state_d != StIdle);
            penable <= (state_d == StAccess);

            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end

            // Counts ACCESS cycles that end without pready; cleared elsewhere.
            if ((state_q == StAccess) && !complete) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end else begin
                wait_cnt_q <= '0;
            end

            rsp_valid <= complete;
            if (complete) begin
                // Without a timeout, completion implies psel&&penable&&pready.
                rsp_err     <= timeout_hit ? 1'b1 : pslverr;
                rsp_timeout <= timeout_hit;
                rsp_rdata   <= (!timeout_hit && !pwrite) ? prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned TO = 16;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rsp_valid_prev = 1'b0;

    apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every response pulse is matched against the oldest
    // expectation pushed by the stimulus.
    always @(negedge pclk) begin
        if (presetn && rsp_valid) begin
            check("rsp_pulse_width", {31'd0, rsp_valid_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at %0t", $time);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
            end
        end
        rsp_valid_prev = rsp_valid;
    end

    // One transfer with the responder stalling for `waits` ACCESS cycles
    // (waits >= TO never asserts pready).
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] rdata, input logic slverr,
                        input logic [DW-1:0] exp_rdata, input logic exp_err,
                        input logic exp_to);
        int   psel_n = 0;
        int   pen_n  = 0;
        int   exp_pen;
        bit   done   = 0;
        logic rdy;
        rsp_t e;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = rdata;
        #1 check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.to    = exp_to;
        exp_q.push_back(e);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        cmd_write = ~wr;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge pclk);
            if (rsp_valid) begin
                done = 1;
                check("psel_after_done", {31'd0, psel}, 32'd0);
            end else begin
                if (psel) begin
                    psel_n++;
                    check("paddr_stable", {24'd0, paddr}, {24'd0, addr});
                    check("pwrite_stable", {31'd0, pwrite}, {31'd0, wr});
                    check("pwdata_stable", pwdata, wdata);
                end
                if (penable) begin
                    pen_n++;
                    rdy     = (pen_n > waits);
                    pready  = rdy;
                    pslverr = rdy ? slverr : 1'b0;
                    #1 check("cmd_ready_access", {31'd0, cmd_ready},
                             {31'd0, rdy || (pen_n == TO)});
                end else begin
                    pready = 1'b0;
                    if (psel) #1 check("cmd_ready_setup", {31'd0, cmd_ready}, 32'd0);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait: got no rsp_valid expected one within 40 cycles");
        end
        exp_pen = (waits >= TO) ? TO : waits + 1;
        check("penable_cycles", pen_n, exp_pen);
        check("psel_cycles", psel_n, exp_pen + 1);
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    initial begin
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset values
        #3;
        check("rst_psel", {31'd0, psel}, 32'd0);
        check("rst_penable", {31'd0, penable}, 32'd0);
        check("rst_pwrite", {31'd0, pwrite}, 32'd0);
        check("rst_paddr", {24'd0, paddr}, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;

        // Zero-wait write
        xfer(1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        // Read with one wait state
        xfer(1'b0, 8'h20, 32'h0, 1, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0);
        @(negedge pclk);
        check("rsp_rdata_hold", rsp_rdata, 32'h12345678);
        // Slave error, then a normal read
        xfer(1'b1, 8'hC9, 32'h55AA55AA, 0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        xfer(1'b0, 8'h22, 32'h0, 0, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0, 1'b0);
        // Timeout: pready never rises, rdata forced to zero
        xfer(1'b0, 8'h50, 32'h0, 255, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 1'b1);

        // Back-to-back: write 0x30 then read 0x31, cmd_valid held high
        @(negedge pclk);
        pready    = 1'b1;
        prdata    = 32'hCAFEF00D;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h30;
        cmd_wdata = 32'h00000001;
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        exp_q.push_back('{32'hCAFEF00D, 1'b0, 1'b0});
        @(posedge pclk);
        #1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h31;
        cmd_wdata = 32'h00000002;
        @(negedge pclk);
        check("b2b_a_setup", {29'd0, psel, penable, rsp_valid}, 32'b100);
        check("b2b_a_setup_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge pclk);
        check("b2b_a_access", {29'd0, psel, penable, rsp_valid}, 32'b110);
        check("b2b_a_access_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        @(negedge pclk);
        check("b2b_b_setup", {29'd0, psel, penable, rsp_valid}, 32'b101);
        check("b2b_b_paddr", {24'd0, paddr}, 32'h31);
        @(negedge pclk);
        check("b2b_b_access", {29'd0, psel, penable, rsp_valid}, 32'b110);
        @(negedge pclk);
        check("b2b_done", {29'd0, psel, penable, rsp_valid}, 32'b001);
        pready = 1'b0;

        // Reset mid-ACCESS aborts with no response
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h40;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        check("abort_in_access", {31'd0, penable}, 32'd1);
        #2 presetn = 1'b0;
        #1;
        check("abort_psel", {31'd0, psel}, 32'd0);
        check("abort_penable", {31'd0, penable}, 32'd0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        xfer(1'b0, 8'h44, 32'h0, 0, 32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 1'b0, 1'b0);

        repeat (3) @(negedge pclk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got no finish expected finish by 20000");
        $fatal(1);
    end

endmodule
